// File: rtl/fir_mac_scheduler.sv
// Round-robin scheduler that time-shares one serial FIR MAC engine among NUM_CH sample requesters.
// Optional HOLD watchdog: define FIR_SCHED_WATCHDOG_EN to drop results the sink never accepts.
module fir_mac_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int TAPS       = 16,
  parameter int DATA_WIDTH = 18
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_CH-1:0]            i_req,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  output logic [NUM_CH-1:0]            o_grant,
  output logic                         o_mac_load,
  output logic                         o_mac_clr,
  output logic                         o_mac_en,
  output logic [CH_W-1:0]              o_mac_ch,
  output logic [DATA_WIDTH-1:0]        o_mac_data,
  output logic [3:0]                   o_tap_idx,
  input  logic [DATA_WIDTH-1:0]        i_mac_result,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [DATA_WIDTH-1:0]        o_out_data,
  output logic [CH_W-1:0]              o_out_ch,
  output logic                         o_busy,
  output logic                         o_drop
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, HOLD} state_t;

  state_t                        state, state_n;
  logic [CH_W-1:0]               ptr, winner, ptr_next;
  logic [NUM_CH-1:0]             onehot;
  logic                          start;
  logic signed [DATA_WIDTH-1:0]  sample;
`ifdef FIR_SCHED_WATCHDOG_EN
  logic [7:0]                    wd_cnt;
  logic                          timeout;
`endif

  // First requester at or after the pointer, wrapping modulo NUM_CH.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                               input logic [CH_W-1:0]   base);
    logic [CH_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(base) + i) % NUM_CH;
      if (!found && req[idx]) begin
        pick  = CH_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    winner   = rr_pick(i_req, ptr);
    ptr_next = (winner == CH_W'(NUM_CH-1)) ? '0 : winner + 1'b1;
    onehot   = '0;
    onehot[winner] = 1'b1;
    sample   = $signed(i_data[winner*DATA_WIDTH +: DATA_WIDTH]);
`ifdef FIR_SCHED_WATCHDOG_EN
    timeout  = 1'b0;
`endif
    case (state)
      IDLE: if (|i_req) begin
        state_n = LOAD;
        start   = 1'b1;
      end
      LOAD: state_n = RUN;
      RUN:  if (o_tap_idx == 4'(TAPS-1)) state_n = CAPT;
      CAPT: state_n = HOLD;
      HOLD: begin
        if (i_out_ready) begin
          state_n = IDLE;
`ifdef FIR_SCHED_WATCHDOG_EN
        // Ready at the timeout edge wins, so the drop path sits behind it.
        end else if (wd_cnt == 8'd254) begin
          state_n = IDLE;
          timeout = 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      ptr         <= '0;
      o_grant     <= '0;
      o_mac_load  <= 1'b0;
      o_mac_clr   <= 1'b0;
      o_mac_en    <= 1'b0;
      o_mac_ch    <= '0;
      o_mac_data  <= '0;
      o_tap_idx   <= '0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_ch    <= '0;
      o_busy      <= 1'b0;
    end else begin
      state      <= state_n;
      o_grant    <= start ? onehot : '0;
      o_mac_load <= start;
      o_mac_clr  <= start;
      o_mac_data <= start ? sample : '0;
      o_mac_en   <= (state_n == RUN);
      o_tap_idx  <= (state == RUN && state_n == RUN) ? o_tap_idx + 4'd1 : 4'd0;
      o_busy     <= (state_n != IDLE);
      if (start) begin
        o_mac_ch <= winner;
        ptr      <= ptr_next;
      end
      // Result is captured from the engine one cycle after the last tap.
      if (state == CAPT) begin
        o_out_valid <= 1'b1;
        o_out_data  <= i_mac_result;
        o_out_ch    <= o_mac_ch;
      end else if (state == HOLD && state_n == IDLE) begin
        o_out_valid <= 1'b0;
      end
    end
  end

`ifdef FIR_SCHED_WATCHDOG_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_cnt <= '0;
      o_drop <= 1'b0;
    end else begin
      o_drop <= timeout;
      if (state == CAPT)
        wd_cnt <= '0;
      else if (state == HOLD && !i_out_ready)
        wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign o_drop = 1'b0;
`endif

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: arbitration order, job timing, result handshake, reset and HOLD timeout.
module tb_fir_mac_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [71:0] data;
  logic [3:0]  grant;
  logic        mac_load, mac_clr, mac_en;
  logic [1:0]  mac_ch;
  logic [17:0] mac_data;
  logic [3:0]  tap_idx;
  logic [17:0] mac_result;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic [1:0]  out_ch;
  logic        busy;
  logic        drop;

  int checks = 0;
  int errors = 0;

  fir_mac_scheduler #(.NUM_CH(4), .CH_W(2), .TAPS(16), .DATA_WIDTH(18)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .o_grant(grant),
    .o_mac_load(mac_load), .o_mac_clr(mac_clr), .o_mac_en(mac_en), .o_mac_ch(mac_ch),
    .o_mac_data(mac_data), .o_tap_idx(tap_idx), .i_mac_result(mac_result),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_ch(out_ch), .o_busy(busy), .o_drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (busy && w < 60) begin @(negedge clk); w++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle busy got %b want 0", tag, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if ({mac_load, mac_clr, mac_en} !== 3'b000) begin errors++; $display("FAIL reset_mac_ctl got %b want 000", {mac_load, mac_clr, mac_en}); end
    checks++; if ({mac_ch, tap_idx} !== 6'd0) begin errors++; $display("FAIL reset_ch_tap got %h want 0", {mac_ch, tap_idx}); end
    checks++; if ({out_valid, busy, drop} !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", {out_valid, busy, drop}); end
    checks++; if (out_data !== 18'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    req = 4'b0000; rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_single;
    int ngrant;
    do_reset();
    data = '0; data[2*18 +: 18] = 18'h00123; mac_result = 18'h0ABCD; out_ready = 1'b1;
    req = 4'b0100; ngrant = 0;
    @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", grant); end
    checks++; if ({mac_load, mac_clr, mac_en} !== 3'b110) begin errors++; $display("FAIL single_load_clr got %b want 110", {mac_load, mac_clr, mac_en}); end
    checks++; if (mac_ch !== 2'd2) begin errors++; $display("FAIL single_mac_ch got %0d want 2", mac_ch); end
    checks++; if (mac_data !== 18'h00123) begin errors++; $display("FAIL single_mac_data got %h want 00123", mac_data); end
    req = 4'b0000;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (grant !== 4'b0000) ngrant++;
      checks++;
      if (mac_en !== 1'b1 || tap_idx !== 4'(t) || mac_load !== 1'b0) begin
        errors++; $display("FAIL single_run tap got en=%b idx=%0d load=%b want en=1 idx=%0d load=0", mac_en, tap_idx, mac_load, t);
      end
    end
    @(negedge clk);
    checks++; if ({mac_en, out_valid, tap_idx} !== 6'd0) begin errors++; $display("FAIL single_capt got en=%b valid=%b tap=%0d want 0 0 0", mac_en, out_valid, tap_idx); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 18'h0ABCD || out_ch !== 2'd2) begin
      errors++; $display("FAIL single_result got v=%b d=%h ch=%0d want v=1 d=0abcd ch=2", out_valid, out_data, out_ch);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got v=%b busy=%b want 0 0", out_valid, busy); end
    checks++; if (mac_ch !== 2'd2) begin errors++; $display("FAIL single_keep_ch got %0d want 2", mac_ch); end
    checks++; if (ngrant !== 0) begin errors++; $display("FAIL single_regrant got %0d extra grants want 0", ngrant); end
  endtask

  task automatic test_back_to_back;
    int gch[6];
    int gcyc[6];
    int n, cyc, idx;
    do_reset();
    out_ready = 1'b1; mac_result = 18'h00055; req = 4'b1111;
    n = 0; cyc = 0;
    for (int i = 0; i < 6; i++) begin gch[i] = -1; gcyc[i] = 0; end
    while (n < 6 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (grant !== 4'b0000) begin
        idx = -1;
        for (int b = 0; b < 4; b++) if (grant == (4'b0001 << b)) idx = b;
        gch[n] = idx; gcyc[n] = cyc; n++;
      end
    end
    req = 4'b0000;
    checks++; if (n != 6) begin errors++; $display("FAIL b2b_count got %0d grants want 6", n); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (gch[i] != i % 4) begin errors++; $display("FAIL b2b_order[%0d] got ch %0d want ch %0d", i, gch[i], i % 4); end
    end
    for (int i = 1; i < 6; i++) begin
      checks++; if (gcyc[i] - gcyc[i-1] != 20) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 20", i, gcyc[i] - gcyc[i-1]); end
    end
    wait_idle("b2b");
  endtask

  task automatic test_hold_stall;
    int w;
    do_reset();
    data = '0; data[0 +: 18] = 18'h1F000; mac_result = 18'h3FFFF; out_ready = 1'b0;
    req = 4'b0001;
    w = 0; while (grant === 4'b0000 && w < 5) begin @(negedge clk); w++; end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL stall_grant0 got %b want 0001", grant); end
    req = 4'b0010;
    w = 0; while (out_valid !== 1'b1 && w < 30) begin
      @(negedge clk); w++;
      if (grant !== 4'b0000) begin checks++; errors++; $display("FAIL stall_busy_grant got %b want 0000", grant); end
    end
    checks++; if (w != 18) begin errors++; $display("FAIL stall_latency got %0d cycles want 18", w); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 18'h3FFFF || out_ch !== 2'd0 || grant !== 4'b0000) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b d=%h ch=%0d g=%b want v=1 d=3ffff ch=0 g=0000", i, out_valid, out_data, out_ch, grant);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_accept got v=%b g=%b busy=%b want 0 0000 0", out_valid, grant, busy);
    end
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL stall_next_grant got %b want 0010", grant); end
    req = 4'b0000;
    wait_idle("stall");
  endtask

  task automatic test_reset_mid;
    int w, nvalid;
    do_reset();
    out_ready = 1'b1; mac_result = 18'h01111; req = 4'b0010;
    w = 0; while (grant === 4'b0000 && w < 5) begin @(negedge clk); w++; end
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL midrst_grant1 got %b want 0010", grant); end
    req = 4'b0000;
    w = 0; while (!(mac_en === 1'b1 && tap_idx === 4'd7) && w < 20) begin @(negedge clk); w++; end
    checks++; if (tap_idx !== 4'd7) begin errors++; $display("FAIL midrst_reach_tap got %0d want 7", tap_idx); end
    rst = 1'b1; req = 4'b1001;
    @(negedge clk);
    checks++; if ({grant, mac_load, mac_clr, mac_en, tap_idx, mac_ch} !== 13'd0) begin
      errors++; $display("FAIL midrst_outputs got g=%b ctl=%b tap=%0d ch=%0d want all 0", grant, {mac_load, mac_clr, mac_en}, tap_idx, mac_ch);
    end
    checks++; if ({busy, out_valid, drop} !== 3'b000) begin errors++; $display("FAIL midrst_status got %b want 000", {busy, out_valid, drop}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL midrst_ptr_grant got %b want 0001", grant); end
    req = 4'b0000; nvalid = 0;
    for (int i = 0; i < 17; i++) begin @(negedge clk); if (out_valid) nvalid++; end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL midrst_stale_valid got %0d valid cycles want 0", nvalid); end
    wait_idle("midrst");
  endtask

  task automatic test_wrap;
    int w;
    do_reset();
    out_ready = 1'b1; mac_result = 18'h00777; req = 4'b1000;
    w = 0; while (grant === 4'b0000 && w < 5) begin @(negedge clk); w++; end
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b want 1000", grant); end
    req = 4'b1001;
    @(negedge clk);
    w = 0; while (grant === 4'b0000 && w < 40) begin @(negedge clk); w++; end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_second got %b want 0001", grant); end
    req = 4'b1000;
    @(negedge clk);
    w = 0; while (grant === 4'b0000 && w < 40) begin @(negedge clk); w++; end
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL wrap_third got %b want 1000", grant); end
    req = 4'b0000;
    wait_idle("wrap");
  endtask

  task automatic test_hold_timeout;
    int w;
    do_reset();
    out_ready = 1'b0; mac_result = 18'h20001; req = 4'b0100;
    w = 0; while (grant === 4'b0000 && w < 5) begin @(negedge clk); w++; end
    req = 4'b0000;
    w = 0; while (out_valid !== 1'b1 && w < 30) begin @(negedge clk); w++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL timeout_valid got %b want 1", out_valid); end
`ifdef FIR_SCHED_WATCHDOG_EN
    begin
      int hc;
      bit dropped;
      hc = 0; dropped = 1'b0;
      while (!dropped && hc < 300) begin
        if (drop === 1'b1) dropped = 1'b1;
        else begin if (out_valid) hc++; @(negedge clk); end
      end
      checks++; if (!dropped || hc != 255) begin errors++; $display("FAIL timeout_drop got dropped=%b hold=%0d want 1 255", dropped, hc); end
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got v=%b busy=%b want 0 0", out_valid, busy); end
      @(negedge clk);
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b want 0", drop); end
    end
`else
    begin
      int lowv, hidrop, bad;
      lowv = 0; hidrop = 0; bad = 0;
      for (int i = 0; i < 1005; i++) begin
        @(negedge clk);
        if (out_valid !== 1'b1) lowv++;
        if (drop !== 1'b0) hidrop++;
        if (out_data !== 18'h20001 || out_ch !== 2'd2) bad++;
      end
      checks++; if (lowv != 0) begin errors++; $display("FAIL nowd_valid got %0d low cycles want 0", lowv); end
      checks++; if (hidrop != 0) begin errors++; $display("FAIL nowd_drop got %0d high cycles want 0", hidrop); end
      checks++; if (bad != 0) begin errors++; $display("FAIL nowd_stable got %0d changed cycles want 0", bad); end
    end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    wait_idle("timeout");
  endtask

  initial begin
    rst = 1'b1; req = '0; data = '0; mac_result = '0; out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_stall();
    test_reset_mid();
    test_wrap();
    test_hold_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
